mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Shared memory-port controller between instruction fetch and the MEM stage. It serialises each 1/2/4-byte request into byte-wide accesses on the single synchronous RAM port. It also arbitrates between the two requesters and reports per-port progress through the INIT/BUSY/DONE status handshake that the MEM stage consumes.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports.

Ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- if_req  in  1  instruction fetch request; always a 4-byte read.
- if_addr  in  ADDR_W  fetch byte address.
- if_data  out  32  fetched word, little-endian.
- if_status  out  2  INIT=2'b00, BUSY=2'b01, DONE=2'b10.
- rw_mem  in  2  MEM request: 01 read, 10 write; 00 and 11 mean no request.
- addr_mem  in  ADDR_W  MEM byte address.
- data_to_mem  in  32  store data; byte k = data_to_mem[8k+7:8k].
- mem_times  in  3  byte count; only 3'b001, 3'b010 and 3'b100 are legal.
- data_from_mem  out  32  load data, zero-filled above mem_times bytes.
- mem_status  out  2  same encoding as if_status.
- ram_a  out  ADDR_W  RAM byte address.
- ram_dout  out  8  RAM write byte.
- ram_wr  out  1  RAM write enable, ANDed with rdy.
- ram_din  in  8  RAM read byte, valid one cycle after ram_a.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- Registers:
  - owner (IF or MEM)
  - cnt[2:0]
  - len[2:0]
  - base address
  - write data
  - a 32-bit read assembly register
- IDLE: sample requests at each rdy-qualified edge.
  - A valid MEM request takes priority over if_req.
  - The losing port keeps status INIT and is served later.
  - A read goes to READ and a write goes to WRITE; cnt=0.
  - len = mem_times for MEM, 4 for IF.
- READ:
  - Drive ram_a = base+cnt while cnt<len.
  - At each edge with cnt>=1, capture ram_din into byte cnt-1; cnt increments.
  - At the edge where cnt==len, capture the last byte and go to DONE.
- WRITE:
  - Drive ram_a = base+cnt, ram_dout = byte cnt, ram_wr=1.
  - cnt increments each edge; at the edge where cnt==len-1, go to DONE.
- DONE:
  - Owner status = DONE for exactly one cycle. Owner's data output holds the assembled value; the upper bytes beyond len are 0.
  - Unconditional transition to IDLE.
  - A request still asserted during DONE is ignored. The requester drops it combinationally on DONE.
- Status per port:
  - Owner sees BUSY in READ/WRITE and DONE in DONE.
  - A non-owner, or any port while IDLE, sees INIT.
- Requesters hold address, data and mem_times stable from request until DONE. There is no preemption: an in-flight IF transfer completes before a MEM request is served.
- Outside WRITE, ram_wr=0 and ram_dout=0. Outside READ/WRITE, ram_a=0.
- Address arithmetic is base+cnt, modulo 2^ADDR_W (wraps at the top of the address space).
- if_data / data_from_mem update only in DONE for their own port and otherwise hold their last value.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all registers 0, both statuses INIT, if_data=0, data_from_mem=0, ram_a=0, ram_dout=0, ram_wr=0.
- Reset mid-transfer aborts with no DONE. A partial write leaves the already-written bytes in RAM.
- rdy=0: state, cnt and data registers hold; ram_wr forced 0; outputs otherwise hold. The transfer resumes unchanged when rdy returns to 1.
- Latency counts cycles after the accepting edge e0:
  - N-byte read: ram_a=base+k in cycle k+1; status DONE in cycle N+2 (4-byte read: cycle 6).
  - N-byte write: ram_wr in cycles 1..N; status DONE in cycle N+1 (1-byte store: cycle 2).
- The earliest next acceptance is the edge ending the cycle after DONE.
- Simultaneous IF and MEM requests in IDLE: MEM is accepted; IF is accepted at the first IDLE edge after MEM's DONE.

## Test plan
- 4-byte IF read at 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_a 0x100..0x103 in cycles 1-4; if_status DONE in cycle 6 with if_data=0x00100513; mem_status INIT throughout.
- MEM store, mem_times=3'b010, addr 0x20, data 0xDEADBEEF -> ram_wr in cycles 1-2 writing 0xEF@0x20 and 0xBE@0x21; mem_status DONE in cycle 3.
- MEM 1-byte read of 0x80 at 0x40 -> data_from_mem=0x00000080 (zero-filled); DONE in cycle 3.
- if_req and rw_mem=01 asserted on the same edge -> MEM served first; if_status stays INIT until MEM's DONE; IF is accepted one cycle after that DONE and its data is correct.
- rdy held low for 3 cycles mid 4-byte write -> no ram_wr during the stall, cnt frozen, all 4 bytes written exactly once, DONE 3 cycles later than nominal.
- rst pulsed in the middle of a read -> all outputs return to 0/INIT immediately; the next request runs normally from IDLE.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: shared RAM-port controller for instruction fetch and the MEM stage.
// Each 1/2/4-byte request is serialised into byte accesses on one synchronous
// RAM port. MEM requests win arbitration in IDLE, and each port sees its own
// INIT/BUSY/DONE status.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic [1:0]        if_status,
    input  logic [1:0]        rw_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [31:0]       data_to_mem,
    input  logic [2:0]        mem_times,
    output logic [31:0]       data_from_mem,
    output logic [1:0]        mem_status,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_data_q, mem_data_d;

    logic              mem_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wr_byte;
    logic [31:0]       rdata_next;

    assign mem_valid = (rw_mem == 2'b01) || (rw_mem == 2'b10);
    assign cur_addr  = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};

    // Byte of the store word selected by the current byte counter.
    always_comb begin
        wr_byte = wdata_q[7:0];
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    // Read assembly with the byte returned by the RAM placed at lane cnt-1.
    always_comb begin
        rdata_next = rdata_q;
        case (cnt_q)
            3'd1:    rdata_next = {rdata_q[31:8], ram_din};
            3'd2:    rdata_next = {rdata_q[31:16], ram_din, rdata_q[7:0]};
            3'd3:    rdata_next = {rdata_q[31:24], ram_din, rdata_q[15:0]};
            3'd4:    rdata_next = {ram_din, rdata_q[23:0]};
            default: rdata_next = rdata_q;
        endcase
    end

    // Next-state logic: arbitration in IDLE, byte sequencing in READ/WRITE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    owner_d = OWNER_MEM;
                    base_d  = addr_mem;
                    wdata_d = data_to_mem;
                    len_d   = mem_times;
                    cnt_d   = 3'd0;
                    rdata_d = 32'd0;
                    state_d = (rw_mem == 2'b01) ? READ : WRITE;
                end else if (if_req) begin
                    owner_d = OWNER_IF;
                    base_d  = if_addr;
                    wdata_d = 32'd0;
                    len_d   = 3'd4;
                    cnt_d   = 3'd0;
                    rdata_d = 32'd0;
                    state_d = READ;
                end
            end
            READ: begin
                if (cnt_q != 3'd0) begin
                    rdata_d = rdata_next;
                end
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    if (owner_q == OWNER_MEM) begin
                        mem_data_d = rdata_next;
                    end else begin
                        if_data_d = rdata_next;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (cnt_q == (len_q - 3'd1)) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; rdy low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_IF;
            cnt_q      <= 3'd0;
            len_q      <= 3'd0;
            base_q     <= '0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            if_data_q  <= 32'd0;
            mem_data_q <= 32'd0;
        end else if (rdy) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
        end
    end

    // RAM port drive; address and data are zero whenever not in use.
    always_comb begin
        ram_a    = '0;
        ram_dout = 8'd0;
        ram_wr   = 1'b0;
        case (state_q)
            READ: begin
                if (cnt_q < len_q) begin
                    ram_a = cur_addr;
                end
            end
            WRITE: begin
                ram_a    = cur_addr;
                ram_dout = wr_byte;
                ram_wr   = rdy;
            end
            default: begin
                ram_a = '0;
            end
        endcase
    end

    // Per-port status: only the owner ever leaves INIT.
    always_comb begin
        if_status  = ST_INIT;
        mem_status = ST_INIT;
        case (state_q)
            READ, WRITE: begin
                if (owner_q == OWNER_MEM) begin
                    mem_status = ST_BUSY;
                end else begin
                    if_status = ST_BUSY;
                end
            end
            DONE: begin
                if (owner_q == OWNER_MEM) begin
                    mem_status = ST_DONE;
                end else begin
                    if_status = ST_DONE;
                end
            end
            default: begin
                if_status  = ST_INIT;
                mem_status = ST_INIT;
            end
        endcase
    end

    assign if_data       = if_data_q;
    assign data_from_mem = mem_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized bench for mem_ctrl with a
// transaction-level expectation schedule and a byte-wide RAM model.
module tb_mem_ctrl;

    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic [1:0]  if_status;
    logic [1:0]  rw_mem;
    logic [31:0] addr_mem;
    logic [31:0] data_to_mem;
    logic [2:0]  mem_times;
    logic [31:0] data_from_mem;
    logic [1:0]  mem_status;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din = 8'd0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_data(if_data),
        .if_status(if_status),
        .rw_mem(rw_mem),
        .addr_mem(addr_mem),
        .data_to_mem(data_to_mem),
        .mem_times(mem_times),
        .data_from_mem(data_from_mem),
        .mem_status(mem_status),
        .ram_a(ram_a),
        .ram_dout(ram_dout),
        .ram_wr(ram_wr),
        .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic [1:0]  ifs;
        logic [1:0]  mems;
        logic [31:0] ifd;
        logic [31:0] memd;
    } exp_t;

    exp_t        sched[$];
    logic [31:0] exp_if_data  = 32'd0;
    logic [31:0] exp_mem_data = 32'd0;
    logic [7:0]  ram[4096];
    logic [7:0]  shadow[4096];
    logic [31:0] la = 32'd0;
    logic        lw = 1'b0;
    logic [7:0]  ld = 8'd0;
    int          wr_total = 0;
    int          check_count = 0;
    int          pass_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Queue the cycle-by-cycle outputs a transfer must produce after acceptance.
    task automatic buildXfer(input bit own_mem, input bit is_wr, input logic [31:0] base,
                             input logic [31:0] wdata, input int n);
        exp_t        e;
        logic [31:0] rd;
        logic [31:0] addr;
        rd = 32'd0;
        for (int k = 0; k < n; k++) begin
            addr = base + 32'(k);
            rd   = rd | ({24'd0, shadow[addr[11:0]]} << (8 * k));
        end
        e.ifs  = own_mem ? ST_INIT : ST_BUSY;
        e.mems = own_mem ? ST_BUSY : ST_INIT;
        e.ifd  = exp_if_data;
        e.memd = exp_mem_data;
        if (is_wr) begin
            for (int k = 0; k < n; k++) begin
                e.a    = base + 32'(k);
                e.wr   = 1'b1;
                e.dout = 8'(wdata >> (8 * k));
                sched.push_back(e);
            end
        end else begin
            for (int k = 0; k <= n; k++) begin
                e.a    = (k < n) ? base + 32'(k) : 32'd0;
                e.wr   = 1'b0;
                e.dout = 8'd0;
                sched.push_back(e);
            end
        end
        e.a    = 32'd0;
        e.wr   = 1'b0;
        e.dout = 8'd0;
        e.ifs  = own_mem ? ST_INIT : ST_DONE;
        e.mems = own_mem ? ST_DONE : ST_INIT;
        e.ifd  = (!own_mem && !is_wr) ? rd : exp_if_data;
        e.memd = (own_mem && !is_wr) ? rd : exp_mem_data;
        sched.push_back(e);
    endtask

    // RAM model plus reference model: advance one schedule step per enabled edge.
    initial begin
        exp_t cur;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h020] = 8'h11; ram[12'h021] = 8'h22; ram[12'h022] = 8'h55; ram[12'h023] = 8'h00;
        ram[12'h040] = 8'h80;
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
        for (int i = 0; i < 4096; i++) shadow[i] = ram[i];
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                sched.delete();
                exp_if_data  = 32'd0;
                exp_mem_data = 32'd0;
            end else if (rdy) begin
                ram_din <= ram[la[11:0]];
                if (lw) begin
                    ram[la[11:0]] = ld;
                    wr_total++;
                end
                if (sched.size() != 0) begin
                    cur = sched.pop_front();
                    if (cur.wr) shadow[cur.a[11:0]] = cur.dout;
                    exp_if_data  = cur.ifd;
                    exp_mem_data = cur.memd;
                end else if (rw_mem == 2'b01) begin
                    buildXfer(1'b1, 1'b0, addr_mem, data_to_mem, int'(mem_times));
                end else if (rw_mem == 2'b10) begin
                    buildXfer(1'b1, 1'b1, addr_mem, data_to_mem, int'(mem_times));
                end else if (if_req) begin
                    buildXfer(1'b0, 1'b0, if_addr, 32'd0, 4);
                end
            end
        end
    end

    // Compare every output against the model once per cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            la = ram_a;
            lw = ram_wr;
            ld = ram_dout;
            if (sched.size() != 0) begin
                e = sched[0];
            end else begin
                e.a = 32'd0; e.wr = 1'b0; e.dout = 8'd0;
                e.ifs = ST_INIT; e.mems = ST_INIT;
                e.ifd = exp_if_data; e.memd = exp_mem_data;
            end
            checkOutput("if_status", {30'd0, if_status}, {30'd0, e.ifs});
            checkOutput("mem_status", {30'd0, mem_status}, {30'd0, e.mems});
            checkOutput("if_data", if_data, e.ifd);
            checkOutput("data_from_mem", data_from_mem, e.memd);
            checkOutput("ram_a", ram_a, e.a);
            checkOutput("ram_dout", {24'd0, ram_dout}, {24'd0, e.dout});
            checkOutput("ram_wr", {31'd0, ram_wr}, {31'd0, e.wr & rdy});
        end
    end

    // Drive one or both requesters, dropping each request when its DONE shows.
    task automatic applyStimulus(input bit do_if, input logic [31:0] ia, input bit do_mem,
                                 input logic [1:0] rw, input logic [31:0] ma,
                                 input logic [31:0] md, input logic [2:0] mt,
                                 input bit rnd_rdy, input int stall_at,
                                 output int if_cyc, output int mem_cyc);
        bit if_done;
        bit mem_done;
        int cyc;
        if_req      = do_if;
        if_addr     = ia;
        rw_mem      = do_mem ? rw : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
        addr_mem    = ma;
        data_to_mem = md;
        mem_times   = mt;
        if_done     = !do_if;
        mem_done    = !do_mem;
        if_cyc      = -1;
        mem_cyc     = -1;
        cyc         = 0;
        while (!(if_done && mem_done) && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
            if (rnd_rdy) rdy = ($urandom_range(0, 4) != 0);
            if (stall_at > 0 && cyc == stall_at) rdy = 1'b0;
            if (stall_at > 0 && cyc == stall_at + 3) rdy = 1'b1;
            if (!if_done && if_status == ST_DONE) begin
                if_done = 1'b1;
                if_cyc  = cyc;
                if_req  = 1'b0;
                rdy     = 1'b1;
            end
            if (!mem_done && mem_status == ST_DONE) begin
                mem_done = 1'b1;
                mem_cyc  = cyc;
                rw_mem   = 2'b00;
                rdy      = 1'b1;
            end
        end
        if (!(if_done && mem_done)) begin
            check_count++;
            $display("[TB] FAIL timeout: no DONE within %0d cycles (if %0b mem %0b)", cyc, if_done, mem_done);
        end
        rdy    = 1'b1;
        if_req = 1'b0;
        rw_mem = 2'b00;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int ic;
        int mc;
        int wr_before;
        bit di;
        bit dm;
        logic [2:0] mt;
        rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        rw_mem = 2'b00; addr_mem = 32'd0; data_to_mem = 32'd0; mem_times = 3'b001;
        #1;
        checkOutput("reset if_status", {30'd0, if_status}, 32'd0);
        checkOutput("reset mem_status", {30'd0, mem_status}, 32'd0);
        checkOutput("reset if_data", if_data, 32'd0);
        checkOutput("reset ram_wr", {31'd0, ram_wr}, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        $display("[TB] IF 4-byte read at 0x100");
        applyStimulus(1'b1, 32'h100, 1'b0, 2'b00, 32'd0, 32'd0, 3'b001, 1'b0, 0, ic, mc);
        checkOutput("if read done cycle", 32'(ic), 32'd6);
        checkOutput("if read data", if_data, 32'h00100513);

        $display("[TB] MEM 2-byte store at 0x20");
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 3'b010, 1'b0, 0, ic, mc);
        checkOutput("store done cycle", 32'(mc), 32'd3);
        checkOutput("store byte 0x20", {24'd0, ram[12'h020]}, 32'hEF);
        checkOutput("store byte 0x21", {24'd0, ram[12'h021]}, 32'hBE);
        checkOutput("store byte 0x22 untouched", {24'd0, ram[12'h022]}, 32'h55);

        $display("[TB] MEM 1-byte read at 0x40");
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b01, 32'h40, 32'd0, 3'b001, 1'b0, 0, ic, mc);
        checkOutput("byte read done cycle", 32'(mc), 32'd3);
        checkOutput("byte read data", data_from_mem, 32'h00000080);

        $display("[TB] simultaneous IF and MEM requests");
        applyStimulus(1'b1, 32'h20, 1'b1, 2'b01, 32'h100, 32'd0, 3'b100, 1'b0, 0, ic, mc);
        checkOutput("arb mem done cycle", 32'(mc), 32'd6);
        checkOutput("arb if done cycle", 32'(ic), 32'd13);
        checkOutput("arb if data", if_data, 32'h0055BEEF);
        checkOutput("arb mem data", data_from_mem, 32'h00100513);

        $display("[TB] 4-byte store with 3-cycle rdy stall");
        wr_before = wr_total;
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b10, 32'h200, 32'h01020304, 3'b100, 1'b0, 2, ic, mc);
        checkOutput("stall done cycle", 32'(mc), 32'd8);
        checkOutput("stall write count", 32'(wr_total - wr_before), 32'd4);
        checkOutput("stall bytes", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'h01020304);

        $display("[TB] reset in the middle of a read");
        rw_mem = 2'b01; addr_mem = 32'h300; mem_times = 3'b100;
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("mid reset mem_status", {30'd0, mem_status}, 32'd0);
        checkOutput("mid reset ram_a", ram_a, 32'd0);
        checkOutput("mid reset if_data", if_data, 32'd0);
        checkOutput("mid reset data_from_mem", data_from_mem, 32'd0);
        rw_mem = 2'b00;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        $display("[TB] MEM 4-byte read wrapping the address space");
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b01, 32'hFFFFFFFE, 32'd0, 3'b100, 1'b0, 0, ic, mc);
        checkOutput("wrap done cycle", 32'(mc), 32'd6);
        checkOutput("wrap data", data_from_mem, 32'hD4C3B2A1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 150; t++) begin
            di = 1'($urandom_range(0, 1));
            dm = 1'($urandom_range(0, 1));
            if (!di && !dm) di = 1'b1;
            case ($urandom_range(0, 2))
                0:       mt = 3'b001;
                1:       mt = 3'b010;
                default: mt = 3'b100;
            endcase
            applyStimulus(di, $urandom, dm, ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01,
                          $urandom, $urandom, mt, 1'b1, 0, ic, mc);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
